fetch_pc_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the KGP-RISC core.
- Consumes the branch decision (branch flag plus 26-bit target word) produced by the branch-decision stage and redirects fetch.
- Runs a single-outstanding req/ack handshake with instruction memory and presents one instruction at a time to decode through a valid/ready handshake.
- On taken calls (opcode 13), emits the return address for the link-register write.

---
 rtl/kgp_pkg.sv | 17 +
 rtl/fetch_pc_reg.sv | 54 +++++
 rtl/fetch_pc_unit.sv | 105 ++++++++++
 tb/tb_fetch_pc_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: opcode values, default widths and the fetch FSM state type.
package kgp_pkg;

    localparam int KGP_ADDR_W   = 32;
    localparam int KGP_OFFSET_W = 26;

    localparam logic [5:0] OP_J    = 6'd3;
    localparam logic [5:0] OP_JR   = 6'd4;
    localparam logic [5:0] OP_CALL = 6'd13;
    localparam logic [5:0] OP_RET  = 6'd14;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC, pending-redirect PC and flush flag with the next-PC / branch-target mux.
// Latency: registered, updates on the cycle after a redirect, ack or accept.
// Backpressure: none of its own; the fetch FSM decides when a PC may advance.
module fetch_pc_reg
    import kgp_pkg::*;
#(
    parameter int                ADDR_W   = KGP_ADDR_W,
    parameter int                OFFSET_W = KGP_OFFSET_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [OFFSET_W-1:0] offset_in,
    input  logic                in_fetch,
    input  logic                imem_ack,
    input  logic                accept,
    input  logic [ADDR_W-1:0]   accept_pc,
    output logic [ADDR_W-1:0]   fetch_pc,
    output logic                flush
);

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pend_pc;

    assign target = ADDR_W'({offset_in, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            flush    <= 1'b0;
        end else if (in_fetch) begin
            if (imem_ack) begin
                // A redirect arriving with the ack is newer than any pending one.
                if (redirect)
                    fetch_pc <= target;
                else if (flush)
                    fetch_pc <= pend_pc;
                flush <= 1'b0;
            end else if (redirect) begin
                // The outstanding request cannot be retracted: remember where to go.
                flush   <= 1'b1;
                pend_pc <= target;
            end
        end else begin
            if (redirect)
                fetch_pc <= target;
            else if (accept)
                fetch_pc <= accept_pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// KGP-RISC fetch stage: single-outstanding imem req/ack, valid/ready to decode, call link strobe.
// Latency: 2 cycles from accept or redirect to the next instr_valid with zero-wait memory.
// Backpressure: instr_valid and its data hold while !instr_ready; no fetch is issued until accepted.
module fetch_pc_unit
    import kgp_pkg::*;
#(
    parameter int                ADDR_W   = KGP_ADDR_W,
    parameter int                OFFSET_W = KGP_OFFSET_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_valid,
    input  logic                branch,
    input  logic [OFFSET_W-1:0] offset_in,
    input  logic                is_call,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr_out,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                link_we,
    output logic [ADDR_W-1:0]   link_addr
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] last_pc;
    logic              flush;
    logic              redirect;
    logic              in_fetch;
    logic              deliver;
    logic              leave_valid;
    logic              accept;

    assign redirect    = br_valid && branch;
    assign in_fetch    = (state_q == FETCH);
    assign deliver     = in_fetch && imem_ack && !redirect && !flush;
    // Redirect beats accept: an instruction seen together with a redirect is squashed.
    assign leave_valid = !in_fetch && (redirect || instr_ready);
    assign accept      = !in_fetch && instr_ready && !redirect;
    assign imem_req    = in_fetch && !rst;
    assign imem_addr   = fetch_pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .redirect  (redirect),
        .offset_in (offset_in),
        .in_fetch  (in_fetch),
        .imem_ack  (imem_ack),
        .accept    (accept),
        .accept_pc (instr_pc),
        .fetch_pc  (fetch_pc),
        .flush     (flush)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (deliver) state_d = VALID;
            VALID:   if (leave_valid) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            link_addr   <= '0;
            last_pc     <= RESET_PC;
        end else begin
            link_we <= redirect && is_call;
            if (redirect && is_call)
                link_addr <= last_pc + ADDR_W'(4);
            if (deliver) begin
                instr_out   <= imem_rdata;
                instr_pc    <= fetch_pc;
                instr_valid <= 1'b1;
            end else if (leave_valid) begin
                instr_valid <= 1'b0;
            end
            if (accept)
                last_pc <= instr_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; memory returns 0xA5000000 | address as the instruction word.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        branch;
    logic [25:0] offset_in;
    logic        is_call;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        link_we;
    logic [31:0] link_addr;
    logic        zw;
    logic        ack_force;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign imem_ack   = zw ? imem_req : ack_force;
    assign imem_rdata = 32'hA500_0000 | imem_addr;

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .branch      (branch),
        .offset_in   (offset_in),
        .is_call     (is_call),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .link_we     (link_we),
        .link_addr   (link_addr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [25:0] off, input logic call);
        br_valid  = 1'b1;
        branch    = 1'b1;
        offset_in = off;
        is_call   = call;
    endtask

    task automatic clr;
        br_valid = 1'b0;
        branch   = 1'b0;
        is_call  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b0; branch = 1'b0; is_call = 1'b0; offset_in = '0;
        instr_ready = 1'b1; zw = 1'b1; ack_force = 1'b0;
        tick; tick;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_link_we", 32'(link_we), 32'd0);
        chk("rst_link_addr", link_addr, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);

        // Zero-wait sequential fetch 0x0, 0x4, 0x8
        rst = 1'b0; #1;
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        tick;
        chk("i0_valid", 32'(instr_valid), 32'd1);
        chk("i0_pc", instr_pc, 32'h0);
        chk("i0_out", instr_out, 32'hA500_0000);
        chk("i0_req_low", 32'(imem_req), 32'd0);
        tick;
        chk("f4_req", 32'(imem_req), 32'd1);
        chk("f4_addr", imem_addr, 32'h4);
        chk("f4_valid", 32'(instr_valid), 32'd0);
        tick;
        chk("i4_valid", 32'(instr_valid), 32'd1);
        chk("i4_pc", instr_pc, 32'h4);
        tick;

        // Three-cycle wait at 0x8
        zw = 1'b0; ack_force = 1'b0;
        chk("w1_addr", imem_addr, 32'h8);
        tick;
        chk("w2_req", 32'(imem_req), 32'd1);
        chk("w2_addr", imem_addr, 32'h8);
        chk("w2_valid", 32'(instr_valid), 32'd0);
        tick;
        ack_force = 1'b1;
        chk("w3_req", 32'(imem_req), 32'd1);
        chk("w3_addr", imem_addr, 32'h8);
        tick;
        ack_force = 1'b0;
        chk("i8_valid", 32'(instr_valid), 32'd1);
        chk("i8_pc", instr_pc, 32'h8);
        chk("i8_out", instr_out, 32'hA500_0008);
        chk("i8_req_low", 32'(imem_req), 32'd0);
        instr_ready = 1'b0;
        tick;
        chk("i8_hold_valid", 32'(instr_valid), 32'd1);
        chk("i8_hold_pc", instr_pc, 32'h8);
        instr_ready = 1'b1;
        tick;

        // Redirect to 0x200 while request at 0xC waits; ack two cycles later
        chk("fc_addr", imem_addr, 32'hC);
        redir(26'h80, 1'b0);
        tick; clr;
        chk("fc_keep_req", 32'(imem_req), 32'd1);
        chk("fc_keep_addr", imem_addr, 32'hC);
        chk("fc_no_valid", 32'(instr_valid), 32'd0);
        tick;
        chk("fc_keep_addr2", imem_addr, 32'hC);
        ack_force = 1'b1;
        tick;
        ack_force = 1'b0;
        chk("fc_dropped", 32'(instr_valid), 32'd0);
        chk("f200_req", 32'(imem_req), 32'd1);
        chk("f200_addr", imem_addr, 32'h200);

        // Ack and redirect (to 0x240) in the same cycle
        ack_force = 1'b1;
        redir(26'h90, 1'b0);
        tick; clr;
        ack_force = 1'b0;
        chk("f200_dropped", 32'(instr_valid), 32'd0);
        chk("f240_addr", imem_addr, 32'h240);
        zw = 1'b1; instr_ready = 1'b0;
        tick;
        chk("i240_valid", 32'(instr_valid), 32'd1);
        chk("i240_pc", instr_pc, 32'h240);
        chk("i240_out", instr_out, 32'hA500_0240);

        // Redirect in VALID with instr_ready=0 squashes the instruction
        redir(26'h40, 1'b0);
        tick; clr;
        chk("sq_valid", 32'(instr_valid), 32'd0);
        chk("sq_req", 32'(imem_req), 32'd1);
        chk("sq_addr", imem_addr, 32'h100);
        tick;
        chk("i100_valid", 32'(instr_valid), 32'd1);
        chk("i100_pc", instr_pc, 32'h100);
        br_valid = 1'b1; branch = 1'b0;
        tick; clr;
        chk("nt_valid", 32'(instr_valid), 32'd1);
        chk("nt_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick;
        chk("f104_addr", imem_addr, 32'h104);
        chk("f104_valid", 32'(instr_valid), 32'd0);

        // Zero-wait ack together with redirect to 0x20
        redir(26'h8, 1'b0);
        tick; clr;
        chk("f20_addr", imem_addr, 32'h20);
        chk("f20_valid", 32'(instr_valid), 32'd0);
        tick;
        chk("i20_valid", 32'(instr_valid), 32'd1);
        chk("i20_pc", instr_pc, 32'h20);
        chk("i20_out", instr_out, 32'hA500_0020);
        tick;
        chk("f24_addr", imem_addr, 32'h24);

        // Taken call: link_addr = last accepted PC + 4
        redir(26'h10, 1'b1);
        tick; clr;
        chk("call_we", 32'(link_we), 32'd1);
        chk("call_addr", link_addr, 32'h24);
        chk("call_fetch", imem_addr, 32'h40);
        chk("call_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;
        tick;
        chk("call_we_pulse", 32'(link_we), 32'd0);
        chk("call_addr_hold", link_addr, 32'h24);
        chk("i40_pc", instr_pc, 32'h40);
        br_valid = 1'b1; branch = 1'b0; is_call = 1'b1;
        tick; clr;
        chk("nt_call_we", 32'(link_we), 32'd0);
        chk("nt_call_valid", 32'(instr_valid), 32'd1);

        // Reset during a waiting request at 0x30
        redir(26'hC, 1'b0);
        tick; clr;
        chk("f30_addr", imem_addr, 32'h30);
        zw = 1'b0; ack_force = 1'b0;
        tick;
        chk("f30_wait_req", 32'(imem_req), 32'd1);
        chk("f30_wait_addr", imem_addr, 32'h30);
        rst = 1'b1; #1;
        chk("mr_req_low", 32'(imem_req), 32'd0);
        tick;
        chk("mr_req_low2", 32'(imem_req), 32'd0);
        chk("mr_valid", 32'(instr_valid), 32'd0);
        chk("mr_link_we", 32'(link_we), 32'd0);
        chk("mr_link_addr", link_addr, 32'h0);
        chk("mr_instr_pc", instr_pc, 32'h0);
        rst = 1'b0; #1;
        chk("mr_restart_req", 32'(imem_req), 32'd1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        zw = 1'b1; instr_ready = 1'b1;
        tick;
        chk("mr_i0_valid", 32'(instr_valid), 32'd1);
        chk("mr_i0_pc", instr_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
